// File: rtl/cnn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_frame_sequencer
//
// Frame-level scheduler in front of cnn_top. On an accepted start it reads
// num_frames images of IMG_PIX pixels each from an external image RAM and
// streams every image as one contiguous burst on cnn_d_in/cnn_in_valid. After
// each burst it waits for the CNN result (or gives up after TIMEOUT cycles),
// captures the result, idles for GAP_CYCLES and then moves to the next frame.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle job start pulse (ignored while busy or on abort)
//   num_frames     frames per job, sampled on an accepted start
//   abort          synchronous abort, returns the block to IDLE
//   busy           job in progress
//   done           one-cycle pulse at the end of a job
//   mem_rd_en      image RAM read strobe
//   mem_addr       image RAM read address
//   mem_rd_data    image RAM data, valid one cycle after mem_rd_en
//   cnn_d_in       pixel to cnn_top
//   cnn_in_valid   pixel valid to cnn_top
//   cnn_d_out      cnn_top result
//   cnn_out_valid  cnn_top result valid
//   res_data       last captured result (held until the next capture)
//   res_valid      one-cycle pulse when res_data is updated
//   res_frame_idx  frame index that res_data belongs to
//   timeout_err    sticky "no result in time" flag, cleared by an accepted start
// ---------------------------------------------------------------------------
module cnn_frame_sequencer #(
    parameter int IMG_PIX    = 784,
    parameter int PIX_W      = 8,
    parameter int RES_W      = 51,
    parameter int ADDR_W     = 16,
    parameter int GAP_CYCLES = 500,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_frames,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  cnn_d_in,
    output logic              cnn_in_valid,
    input  logic [RES_W-1:0]  cnn_d_out,
    input  logic              cnn_out_valid,
    output logic [RES_W-1:0]  res_data,
    output logic              res_valid,
    output logic [7:0]        res_frame_idx,
    output logic              timeout_err
);

    localparam int PIX_CW  = (IMG_PIX    > 1) ? $clog2(IMG_PIX)    : 1;
    localparam int WAIT_CW = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;
    localparam int GAP_CW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PIX_CW-1:0]  PIX_LAST     = PIX_CW'(IMG_PIX - 1);
    localparam logic [WAIT_CW-1:0] WAIT_LAST    = WAIT_CW'(TIMEOUT - 1);
    localparam logic [GAP_CW-1:0]  GAP_LAST     = GAP_CW'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  FRAME_STRIDE = ADDR_W'(IMG_PIX);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT_RES,
        GAP,
        DONE
    } state_t;

    state_t              state_reg;
    logic [7:0]          num_frames_reg;
    logic [7:0]          frame_idx_reg;
    logic [PIX_CW-1:0]   pix_cnt_reg;
    logic [WAIT_CW-1:0]  wait_cnt_reg;
    logic [GAP_CW-1:0]   gap_cnt_reg;
    // Start address of the current frame; frames are packed back to back in
    // the RAM, so this replaces a frame_idx*IMG_PIX multiply.
    logic [ADDR_W-1:0]   frame_base_reg;
    // mem_rd_en delayed by one cycle: marks the cycle in which mem_rd_data
    // carries a requested pixel.
    logic                rd_en_d1_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            num_frames_reg <= '0;
            frame_idx_reg  <= '0;
            pix_cnt_reg    <= '0;
            wait_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            frame_base_reg <= '0;
            rd_en_d1_reg   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_addr       <= '0;
            cnn_d_in       <= '0;
            cnn_in_valid   <= 1'b0;
            res_data       <= '0;
            res_valid      <= 1'b0;
            res_frame_idx  <= '0;
            timeout_err    <= 1'b0;
        end else begin
            // Two-stage pixel pipeline: RAM read latency plus the d_in register.
            rd_en_d1_reg <= mem_rd_en;
            cnn_in_valid <= rd_en_d1_reg;
            if (rd_en_d1_reg) begin
                cnn_d_in <= mem_rd_data;
            end

            res_valid <= 1'b0;
            done      <= 1'b0;

            if (abort) begin
                // Abort also blocks a coincident start in IDLE. The in-flight
                // pipeline valids are dropped so no partial pixels leak out;
                // captured results and the error flag are left untouched.
                state_reg    <= IDLE;
                busy         <= 1'b0;
                mem_rd_en    <= 1'b0;
                rd_en_d1_reg <= 1'b0;
                cnn_in_valid <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            num_frames_reg <= num_frames;
                            frame_idx_reg  <= '0;
                            pix_cnt_reg    <= '0;
                            frame_base_reg <= '0;
                            mem_addr       <= '0;
                            timeout_err    <= 1'b0;
                            if (num_frames == 8'd0) begin
                                // Empty job: finish without touching the RAM.
                                state_reg <= DONE;
                                done      <= 1'b1;
                            end else begin
                                state_reg <= STREAM;
                                busy      <= 1'b1;
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end

                    STREAM: begin
                        // mem_addr always equals frame_base + pix_cnt here.
                        if (pix_cnt_reg == PIX_LAST) begin
                            state_reg    <= WAIT_RES;
                            mem_rd_en    <= 1'b0;
                            wait_cnt_reg <= '0;
                        end else begin
                            pix_cnt_reg <= pix_cnt_reg + PIX_CW'(1);
                            mem_addr    <= mem_addr + ADDR_W'(1);
                        end
                    end

                    WAIT_RES: begin
                        // A result arriving on the timeout cycle still counts.
                        if (cnn_out_valid) begin
                            res_data      <= cnn_d_out;
                            res_frame_idx <= frame_idx_reg;
                            res_valid     <= 1'b1;
                            state_reg     <= GAP;
                            gap_cnt_reg   <= '0;
                        end else if (wait_cnt_reg == WAIT_LAST) begin
                            timeout_err <= 1'b1;
                            state_reg   <= GAP;
                            gap_cnt_reg <= '0;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + WAIT_CW'(1);
                        end
                    end

                    GAP: begin
                        if (gap_cnt_reg == GAP_LAST) begin
                            if (frame_idx_reg == num_frames_reg - 8'd1) begin
                                state_reg <= DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                frame_idx_reg  <= frame_idx_reg + 8'd1;
                                pix_cnt_reg    <= '0;
                                frame_base_reg <= frame_base_reg + FRAME_STRIDE;
                                mem_addr       <= frame_base_reg + FRAME_STRIDE;
                                mem_rd_en      <= 1'b1;
                                state_reg      <= STREAM;
                            end
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + GAP_CW'(1);
                        end
                    end

                    DONE: begin
                        state_reg <= IDLE;
                    end

                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        mem_rd_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_frame_sequencer
//
// Directed bench for cnn_frame_sequencer. An image RAM model returns
// RAM[a] = a[7:0] one cycle after each read; a responder plays cnn_top and
// answers a fixed number of cycles after the last pixel of every frame
// (optionally skipping frames). A negedge monitor accumulates counts that
// the linear stimulus sequence then compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cnn_frame_sequencer;

    localparam int IMG_PIX    = 784;
    localparam int PIX_W      = 8;
    localparam int RES_W      = 51;
    localparam int ADDR_W     = 16;
    localparam int GAP_CYCLES = 500;
    localparam int TIMEOUT    = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        num_frames;
    logic              abort;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rd_data = '0;
    logic [PIX_W-1:0]  cnn_d_in;
    logic              cnn_in_valid;
    logic [RES_W-1:0]  cnn_d_out;
    logic              cnn_out_valid;
    logic [RES_W-1:0]  res_data;
    logic              res_valid;
    logic [7:0]        res_frame_idx;
    logic              timeout_err;

    cnn_frame_sequencer #(
        .IMG_PIX(IMG_PIX), .PIX_W(PIX_W), .RES_W(RES_W), .ADDR_W(ADDR_W),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
        .abort(abort), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .cnn_d_in(cnn_d_in),
        .cnn_in_valid(cnn_in_valid), .cnn_d_out(cnn_d_out),
        .cnn_out_valid(cnn_out_valid), .res_data(res_data),
        .res_valid(res_valid), .res_frame_idx(res_frame_idx),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Image RAM model: one-cycle read latency, content = low address byte.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0];
    end

    // ---------------- monitor ----------------
    logic        mon_clr;
    int          cyc;
    int          rd_cnt, addr_err, iv_cnt, pix_err, burst_cnt;
    int          res_cnt, done_cnt, busy_cnt, low_run;
    int          res_cyc, done_cyc, last_rd_cyc, to_delta;
    int          blen [4];
    int          bgap [4];
    logic [50:0] rdat [4];
    logic [7:0]  ridx [4];
    logic [31:0] exp_addr;
    logic [7:0]  exp_pix;
    logic        prev_iv, prev_to;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            rd_cnt <= 0; addr_err <= 0; iv_cnt <= 0; pix_err <= 0;
            burst_cnt <= 0; res_cnt <= 0; done_cnt <= 0; busy_cnt <= 0;
            low_run <= 0; res_cyc <= 0; done_cyc <= 0; last_rd_cyc <= 0;
            to_delta <= 0; exp_addr <= '0; exp_pix <= '0;
            prev_iv <= 1'b0; prev_to <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                blen[k] <= 0; bgap[k] <= 0; rdat[k] <= '0; ridx[k] <= '0;
            end
        end else begin
            if (mem_rd_en) begin
                if (mem_addr !== exp_addr[15:0]) addr_err <= addr_err + 1;
                exp_addr    <= exp_addr + 32'd1;
                rd_cnt      <= rd_cnt + 1;
                last_rd_cyc <= cyc;
            end
            if (cnn_in_valid) begin
                iv_cnt <= iv_cnt + 1;
                if (cnn_d_in !== exp_pix) pix_err <= pix_err + 1;
                exp_pix <= exp_pix + 8'd1;
                if (!prev_iv) begin
                    if (burst_cnt < 4) begin
                        bgap[burst_cnt] <= low_run;
                        blen[burst_cnt] <= 1;
                    end
                    burst_cnt <= burst_cnt + 1;
                end else if (burst_cnt >= 1 && burst_cnt <= 4) begin
                    blen[burst_cnt-1] <= blen[burst_cnt-1] + 1;
                end
                low_run <= 0;
            end else begin
                low_run <= low_run + 1;
            end
            prev_iv <= cnn_in_valid;
            if (res_valid) begin
                if (res_cnt < 4) begin
                    rdat[res_cnt] <= res_data;
                    ridx[res_cnt] <= res_frame_idx;
                end
                res_cnt <= res_cnt + 1;
                res_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy) busy_cnt <= busy_cnt + 1;
            if (timeout_err && !prev_to) to_delta <= cyc - last_rd_cyc;
            prev_to <= timeout_err;
        end
    end

    // ---------------- cnn_top responder ----------------
    logic        resp_clr;
    logic [50:0] resp_base;
    logic [7:0]  skip_mask;
    int          resp_dly;
    int          stray_req;
    int          stray_ack;
    int          r_cnt, r_frame, r_cd;

    initial begin
        cnn_out_valid = 1'b0;
        cnn_d_out     = '0;
        r_cnt = 0; r_frame = 0; r_cd = 0; stray_ack = 0;
        forever begin
            @(negedge clk);
            cnn_out_valid = 1'b0;
            if (resp_clr) begin
                r_cnt = 0; r_frame = 0; r_cd = 0;
            end else begin
                if (r_cd > 0) begin
                    r_cd = r_cd - 1;
                    if (r_cd == 0) begin
                        cnn_out_valid = 1'b1;
                        cnn_d_out     = resp_base + 51'(r_frame - 1);
                    end
                end
                if (cnn_in_valid) begin
                    r_cnt = r_cnt + 1;
                    if (r_cnt == IMG_PIX) begin
                        r_cnt = 0;
                        if (!skip_mask[r_frame[2:0]]) r_cd = resp_dly;
                        r_frame = r_frame + 1;
                    end
                end
                if (stray_req != stray_ack) begin
                    stray_ack     = stray_req;
                    cnn_out_valid = 1'b1;
                    cnn_d_out     = 51'h7_DEAD_BEEF_0000;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        mon_clr  = 1'b1;
        resp_clr = 1'b1;
        step(1);
        mon_clr  = 1'b0;
        resp_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] nf);
        num_frames = nf;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step(1);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_reads(input string tag, input int target);
        for (int i = 0; i < 2000; i++) begin
            if (rd_cnt >= target) break;
            step(1);
        end
        chk(tag, 64'(rd_cnt >= target), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_frames = 8'd0;
        mon_clr = 1'b1; resp_clr = 1'b1; skip_mask = 8'd0;
        resp_dly = 30; resp_base = 51'h123; stray_req = 0;
        step(3);

        // Reset state
        chk("rst_ctl", 64'({busy, done, mem_rd_en, cnn_in_valid, res_valid, timeout_err}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_pix_idx", 64'({cnn_d_in, res_frame_idx}), 64'd0);
        chk("rst_res", 64'(res_data), 64'd0);
        rst = 1'b0; mon_clr = 1'b0; resp_clr = 1'b0;
        step(2);

        // Single frame, result 30 cycles after the last pixel
        clear_mon();
        pulse_start(8'd1);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        wait_done("t1_done_seen", 3000);
        chk("t1_rd_cnt", 64'(rd_cnt), 64'd784);
        chk("t1_addr_err", 64'(addr_err), 64'd0);
        chk("t1_iv_cnt", 64'(iv_cnt), 64'd784);
        chk("t1_pix_err", 64'(pix_err), 64'd0);
        chk("t1_bursts", 64'(burst_cnt), 64'd1);
        chk("t1_burst_len", 64'(blen[0]), 64'd784);
        chk("t1_res_cnt", 64'(res_cnt), 64'd1);
        chk("t1_res_data", 64'(rdat[0]), 64'h123);
        chk("t1_res_idx", 64'(ridx[0]), 64'd0);
        chk("t1_done_after_res", 64'(done_cyc - res_cyc), 64'd500);
        // 784 STREAM + 32 WAIT_RES + 500 GAP cycles
        chk("t1_busy_cycles", 64'(busy_cnt), 64'd1316);
        step(1);
        chk("t1_idle_after", 64'({busy, done, res_valid}), 64'd0);
        chk("t1_res_held", 64'(res_data), 64'h123);

        // Three frames: contiguous addresses, 532 idle cycles between bursts
        // (30 response + 2 pipeline + 500 gap)
        resp_base = 51'h5_5555_0000_0100;
        clear_mon();
        pulse_start(8'd3);
        wait_done("t2_done_seen", 8000);
        chk("t2_rd_cnt", 64'(rd_cnt), 64'd2352);
        chk("t2_addr_err", 64'(addr_err), 64'd0);
        chk("t2_pix_err", 64'(pix_err), 64'd0);
        chk("t2_bursts", 64'(burst_cnt), 64'd3);
        chk("t2_burst_lens", 64'({blen[0][15:0], blen[1][15:0], blen[2][15:0]}),
            64'({16'd784, 16'd784, 16'd784}));
        chk("t2_gap1", 64'(bgap[1]), 64'd532);
        chk("t2_gap2", 64'(bgap[2]), 64'd532);
        chk("t2_res_cnt", 64'(res_cnt), 64'd3);
        chk("t2_res_idx", 64'({ridx[0], ridx[1], ridx[2]}), 64'h000102);
        chk("t2_res_data2", 64'(rdat[2]), 64'h5_5555_0000_0102);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);

        // Frame 0 of 2 gets no result: timeout after 4096 wait cycles
        resp_base = 51'h2A;
        skip_mask = 8'b0000_0001;
        clear_mon();
        pulse_start(8'd2);
        wait_done("t3_done_seen", 12000);
        chk("t3_timeout_err", 64'(timeout_err), 64'd1);
        chk("t3_timeout_delay", 64'(to_delta), 64'd4097);
        chk("t3_gap1", 64'(bgap[1]), 64'd4596);
        chk("t3_iv_cnt", 64'(iv_cnt), 64'd1568);
        chk("t3_res_cnt", 64'(res_cnt), 64'd1);
        chk("t3_res_idx", 64'(ridx[0]), 64'd1);
        chk("t3_res_data", 64'(rdat[0]), 64'h2B);
        skip_mask = 8'd0;

        // Zero-frame job: done one cycle later, no reads, busy never set
        clear_mon();
        pulse_start(8'd0);
        chk("t4_done_pulse", 64'({done, busy}), 64'b10);
        chk("t4_timeout_cleared", 64'(timeout_err), 64'd0);
        step(1);
        chk("t4_done_one_cycle", 64'(done), 64'd0);
        step(5);
        chk("t4_no_reads", 64'(rd_cnt), 64'd0);
        chk("t4_busy_never", 64'(busy_cnt), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);

        // Abort at pixel 400
        clear_mon();
        pulse_start(8'd1);
        wait_reads("t5_reach_400", 400);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_after_abort", 64'({cnn_in_valid, busy, mem_rd_en}), 64'd0);
        step(10);
        chk("t5_rd_cnt", 64'(rd_cnt), 64'd400);
        chk("t5_iv_cnt", 64'(iv_cnt), 64'd398);
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        chk("t5_no_res", 64'(res_cnt), 64'd0);
        chk("t5_res_held", 64'(res_data), 64'h2B);

        // Clean frame after the abort
        resp_base = 51'h77;
        clear_mon();
        pulse_start(8'd1);
        wait_done("t5b_done_seen", 3000);
        chk("t5b_iv_cnt", 64'(iv_cnt), 64'd784);
        chk("t5b_addr_pix_err", 64'(addr_err + pix_err), 64'd0);
        chk("t5b_res", 64'({ridx[0], 5'd0, rdat[0]}), 64'({8'd0, 5'd0, 51'h77}));

        // Start pulse and stray out_valid mid-STREAM are both ignored
        resp_base = 51'h99;
        clear_mon();
        pulse_start(8'd1);
        wait_reads("t6_reach_100", 100);
        num_frames = 8'd5;
        start      = 1'b1;
        stray_req  = stray_req + 1;
        step(1);
        start      = 1'b0;
        wait_done("t6_done_seen", 3000);
        chk("t6_rd_cnt", 64'(rd_cnt), 64'd784);
        chk("t6_addr_err", 64'(addr_err), 64'd0);
        chk("t6_bursts", 64'(burst_cnt), 64'd1);
        chk("t6_res_cnt", 64'(res_cnt), 64'd1);
        chk("t6_res_data", 64'(rdat[0]), 64'h99);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);

        // Asynchronous reset in the middle of a stream
        clear_mon();
        pulse_start(8'd2);
        step(50);
        rst = 1'b1;
        #1;
        chk("t7_async_ctl", 64'({busy, done, mem_rd_en, cnn_in_valid, res_valid, timeout_err}), 64'd0);
        chk("t7_async_data", 64'({mem_addr, cnn_d_in, res_frame_idx}), 64'd0);
        chk("t7_async_res", 64'(res_data), 64'd0);
        step(2);
        rst = 1'b0;
        step(3);
        chk("t7_stays_idle", 64'({busy, mem_rd_en, cnn_in_valid}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
